// File: rtl/pll_sup_pkg.sv
// pll_sup_pkg: shared state encoding, status width and saturating increment
package pll_sup_pkg;
  localparam int STAT_W = 8;
  typedef enum logic [2:0] {RESET_PLL, WAIT_LOCK, STABILIZE, RUN, FAILED} state_t;
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + STAT_W'(1);
  endfunction
endpackage

// File: rtl/pll_lock_supervisor_if.sv
// pll_lock_supervisor_if: PLL control and supervisor status bundle
interface pll_lock_supervisor_if;
  import pll_sup_pkg::*;
  logic locked_in, pll_rst, sys_rst, lock_ok, fail;
  logic [STAT_W-1:0] retry_count, loss_count;
  modport master(input locked_in, output pll_rst, sys_rst, lock_ok, fail, retry_count, loss_count);
  modport slave(output locked_in, input pll_rst, sys_rst, lock_ok, fail, retry_count, loss_count);
endinterface

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer, cleared by rst
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] s1;
  always_ff @(posedge clk)
    if (rst) begin
      s1 <= '0;
      q  <= '0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
endmodule

// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor: resets the PLL, qualifies lock, retries and flags failure
// PLL_LOCK_SUPERVISOR_STATS_EN enables the saturating RUN lock-loss counter.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int RST_PULSE_CYC    = 16,
  parameter int LOCK_TIMEOUT_CYC = 50000,
  parameter int STABLE_CYC       = 1024,
  parameter int MAX_RETRIES      = 4,
  parameter int CNT_W            = 16
) (
  input logic refclk,
  input logic rst,
  pll_lock_supervisor_if.master bus
);
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] ST_LAST  = CNT_W'(STABLE_CYC - 1);
  localparam logic [STAT_W-1:0] RETRY_LAST = STAT_W'(MAX_RETRIES - 1);
  logic locked_s;
  state_t state, nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [STAT_W-1:0] retry, retry_nxt;
  sync_2ff #(.W(1)) u_sync (.clk(refclk), .rst(rst), .d(bus.locked_in), .q(locked_s));
  always_comb begin
    nxt = state;
    cnt_nxt = cnt + CNT_W'(1);
    retry_nxt = retry;
    case (state)
      RESET_PLL: if (cnt == RST_LAST) begin
        nxt = WAIT_LOCK;
        cnt_nxt = '0;
      end
      WAIT_LOCK: if (locked_s) begin
        nxt = STABILIZE;
        cnt_nxt = '0;
      end else if (cnt == TO_LAST) begin
        cnt_nxt = '0;
        nxt = (retry == RETRY_LAST) ? FAILED : RESET_PLL;
        retry_nxt = (retry == RETRY_LAST) ? retry : retry + STAT_W'(1);
      end
      STABILIZE: if (!locked_s) begin
        nxt = WAIT_LOCK;
        cnt_nxt = '0;
      end else if (cnt == ST_LAST) begin
        nxt = RUN;
        cnt_nxt = '0;
        retry_nxt = '0;
      end
      RUN: begin
        cnt_nxt = '0;
        retry_nxt = '0;
        nxt = locked_s ? RUN : RESET_PLL;
      end
      FAILED: cnt_nxt = '0;
      default: begin
        nxt = RESET_PLL;
        cnt_nxt = '0;
      end
    endcase
  end
  // Outputs are decoded from the next state so they change on the transition edge.
  always_ff @(posedge refclk)
    if (rst) begin
      state <= RESET_PLL;
      cnt <= '0;
      retry <= '0;
      bus.pll_rst <= 1'b1;
      bus.sys_rst <= 1'b1;
      bus.lock_ok <= 1'b0;
      bus.fail <= 1'b0;
    end else begin
      state <= nxt;
      cnt <= cnt_nxt;
      retry <= retry_nxt;
      bus.pll_rst <= (nxt == RESET_PLL) || (nxt == FAILED);
      bus.sys_rst <= nxt != RUN;
      bus.lock_ok <= nxt == RUN;
      bus.fail <= nxt == FAILED;
    end
  assign bus.retry_count = retry;
`ifdef PLL_LOCK_SUPERVISOR_STATS_EN
  logic [STAT_W-1:0] loss;
  always_ff @(posedge refclk)
    if (rst) loss <= '0;
    else if (state == RUN && nxt == RESET_PLL) loss <= sat_inc(loss);
  assign bus.loss_count = loss;
`else
  assign bus.loss_count = '0;
`endif
endmodule
